// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-state encoding.
// Other stages import this to decode fetch_state_e on waveforms.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_INSTR_W = 16;
  localparam logic [CPU_INSTR_W-1:0] CPU_NOP = 16'h0000;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_HOLD  = 3'd3,
    FS_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: samples pc, issues one imem read per pc over
// valid/ready, holds the instruction for decode and pulses pc_en on
// accept. flush drops any held or in-flight instruction.
// Ports: clk, rst (sync, active-high), pc, flush,
//   imem_req_{valid,ready,addr}, imem_rsp_{valid,data},
//   instr_{valid,ready}, instr, instr_pc, pc_en.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = CPU_NOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               pc_en
);

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ipc_q;
  logic               pc_en_q;
  // flush seen while the request is still pending
  logic               drop_q;

  logic req_fire;
  logic rsp_take;
  logic accept;

  assign req_fire = (state == FS_REQ) && imem_req_ready;
  assign rsp_take = (state == FS_WAIT) && imem_rsp_valid && !flush;
  assign accept   = (state == FS_HOLD) && instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= FS_IDLE;
    else     state <= state_nxt;
  end

  // IDLE waits out the pc_en cycle (and a flush cycle) so the
  // sampled pc is the one the PC register has just loaded.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FS_IDLE: begin
        if (!pc_en_q && !flush) state_nxt = FS_REQ;
      end
      FS_REQ: begin
        if (imem_req_ready)
          state_nxt = (flush || drop_q) ? FS_DRAIN : FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rsp_valid)
          state_nxt = flush ? FS_IDLE : FS_HOLD;
        else if (flush)
          state_nxt = FS_DRAIN;
      end
      FS_HOLD: begin
        if (flush || instr_ready) state_nxt = FS_IDLE;
      end
      FS_DRAIN: begin
        if (imem_rsp_valid) state_nxt = FS_IDLE;
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      pc_en_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pc_en_q <= accept;
      drop_q  <= (state == FS_REQ) && !req_fire
                 && (flush || drop_q);
      if ((state == FS_IDLE) && (state_nxt == FS_REQ))
        addr_q <= pc;
      if (rsp_take) begin
        instr_q <= imem_rsp_data;
        ipc_q   <= addr_q;
      end
    end
  end

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = addr_q;
  assign instr_valid    = (state == FS_HOLD);
  assign instr          = instr_valid ? instr_q : NOP_INSTR;
  assign instr_pc       = ipc_q;
  assign pc_en          = pc_en_q;

endmodule
